// File: rtl/rf_bank_if.sv
// Request/response bundle between the dispatch/collector side and one register-file bank.
// Latency: none (wires only).
// Backpressure: bk_bz tells the requester to stop presenting hits; there is no per-request ready.
// Modports: master = requester/collector side, slave = bank responder.
interface rf_bank_if #(
    parameter int DW = 32,
    parameter int RW = 3
);
    logic          req_a_en;
    logic [RW-1:0] rowid_a;
    logic [1:0]    bankid_a;
    logic          req_b_en;
    logic [RW-1:0] rowid_b;
    logic [1:0]    bankid_b;
    logic [1:0]    req_ocid;
    logic          wr_en;
    logic [RW-1:0] wr_row;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] bk_data;
    logic          bk_vld;
    logic [1:0]    bk_ocid;
    logic          bk_opsel;
    logic          bk_bz;
    logic          err_ovf;

    modport slave (
        input  req_a_en, rowid_a, bankid_a, req_b_en, rowid_b, bankid_b, req_ocid,
        input  wr_en, wr_row, wr_data,
        output bk_data, bk_vld, bk_ocid, bk_opsel, bk_bz, err_ovf
    );

    modport master (
        output req_a_en, rowid_a, bankid_a, req_b_en, rowid_b, bankid_b, req_ocid,
        output wr_en, wr_row, wr_data,
        input  bk_data, bk_vld, bk_ocid, bk_opsel, bk_bz, err_ovf
    );
endinterface

// File: rtl/rf_bank_responder.sv
// Register-file bank responder: queues operand reads hitting this bank and returns bank data.
// Latency: push in cycle N, pop no earlier than N+1, bk_vld in N+2; each CDB write stalls the pop by 1 cycle.
// Backpressure: bk_bz high when fewer than 2 free entries; excess pushes are dropped and set err_ovf.
// Ports: clk, rst (sync, active high), bus (rf_bank_if.slave: A/B requests, CDB write, bk_* response,
//        bk_bz busy, err_ovf sticky overflow).
// Option: define RF_BYPASS_EN to let reads proceed during a CDB write, forwarding wr_data on a row match.
module rf_bank_responder #(
    parameter int BANKID = 0,
    parameter int DEPTH  = 4,
    parameter int ROWS   = 8,
    parameter int DW     = 32
) (
    input  logic        clk,
    input  logic        rst,
    rf_bank_if.slave    bus
);
    localparam int RW = $clog2(ROWS);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0]    BANK_SEL = 2'(BANKID);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

    typedef struct packed {
        logic [RW-1:0] row;
        logic [1:0]    ocid;
        logic          opsel;
    } req_ent_t;

    req_ent_t      fifo [DEPTH];
    logic [DW-1:0] mem  [ROWS];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          hit_a;
    logic          hit_b;
    logic          pop;
    logic          acc_a;
    logic          acc_b;
    logic          ovf;
    logic [CW-1:0] room;
    logic [CW-1:0] count_nxt;
    req_ent_t      head;
    req_ent_t      ent_a;
    req_ent_t      ent_b;
    logic [DW-1:0] rd_val;

    always_comb begin
        hit_a = bus.req_a_en && (bus.bankid_a == BANK_SEL);
        hit_b = bus.req_b_en && (bus.bankid_b == BANK_SEL);
        ent_a = '{row: bus.rowid_a, ocid: bus.req_ocid, opsel: 1'b0};
        ent_b = '{row: bus.rowid_b, ocid: bus.req_ocid, opsel: 1'b1};
        head  = fifo[rd_ptr];

        // pop is decided on the registered count, so an entry pushed this
        // cycle can never be popped in the same cycle.
`ifdef RF_BYPASS_EN
        pop    = (count != '0);
        rd_val = (bus.wr_en && (bus.wr_row == head.row)) ? bus.wr_data : mem[head.row];
`else
        pop    = (count != '0) && !bus.wr_en;
        rd_val = mem[head.row];
`endif

        // A slot vacated by this cycle's pop is reusable by this cycle's pushes.
        room  = DEPTH_C - count + CW'(pop);
        acc_a = hit_a && (room != '0);
        acc_b = hit_b && (room > CW'(acc_a));
        ovf   = (hit_a && !acc_a) || (hit_b && !acc_b);

        count_nxt = count + CW'(acc_a) + CW'(acc_b) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            bus.bk_data  <= '0;
            bus.bk_vld   <= 1'b0;
            bus.bk_ocid  <= '0;
            bus.bk_opsel <= 1'b0;
            bus.bk_bz    <= 1'b0;
            bus.err_ovf  <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // A is always placed ahead of B when both are accepted.
            if (acc_a) begin
                fifo[wr_ptr] <= ent_a;
            end
            if (acc_b) begin
                fifo[wr_ptr + PW'(acc_a)] <= ent_b;
            end
            wr_ptr <= wr_ptr + PW'(acc_a) + PW'(acc_b);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count_nxt;

            bus.bk_bz   <= (count_nxt > (DEPTH_C - CW'(2)));
            bus.err_ovf <= bus.err_ovf | ovf;

            if (bus.wr_en) begin
                mem[bus.wr_row] <= bus.wr_data;
            end

            // Response fields hold their last value when no pop happens.
            bus.bk_vld <= pop;
            if (pop) begin
                bus.bk_data  <= rd_val;
                bus.bk_ocid  <= head.ocid;
                bus.bk_opsel <= head.opsel;
            end
        end
    end
endmodule

// File: tb/tb_rf_bank_responder.sv
// Bench for rf_bank_responder (BANKID=2, DEPTH=4): directed vector table, hand-written
// corner sequences and randomized traffic checked against a queue-based reference model.
module tb_rf_bank_responder;
    localparam int DW     = 32;
    localparam int DEPTH  = 4;
    localparam int BANKID = 2;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_bank_if #(.DW(DW)) bus();

    rf_bank_responder #(.BANKID(BANKID), .DEPTH(DEPTH), .ROWS(8), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0] row;
        logic [1:0] ocid;
        logic       opsel;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_mem [8];
    logic        exp_vld, exp_opsel, exp_bz, exp_ovf;
    logic [31:0] exp_data;
    logic [1:0]  exp_ocid;

    task automatic model_step();
        bit   pop;
        ent_t e;
        if (rst) begin
            q.delete();
            foreach (m_mem[i]) m_mem[i] = '0;
            exp_vld = 0; exp_data = 0; exp_ocid = 0; exp_opsel = 0; exp_bz = 0; exp_ovf = 0;
            return;
        end
        pop = (q.size() > 0) && (BYP || !bus.wr_en);
        exp_vld = pop;
        if (pop) begin
            e = q.pop_front();
            exp_data  = (BYP && bus.wr_en && bus.wr_row == e.row) ? bus.wr_data : m_mem[e.row];
            exp_ocid  = e.ocid;
            exp_opsel = e.opsel;
        end
        if (bus.req_a_en && bus.bankid_a == 2'(BANKID)) begin
            if (q.size() < DEPTH) q.push_back('{bus.rowid_a, bus.req_ocid, 1'b0});
            else exp_ovf = 1;
        end
        if (bus.req_b_en && bus.bankid_b == 2'(BANKID)) begin
            if (q.size() < DEPTH) q.push_back('{bus.rowid_b, bus.req_ocid, 1'b1});
            else exp_ovf = 1;
        end
        if (bus.wr_en) m_mem[bus.wr_row] = bus.wr_data;
        exp_bz = (q.size() > DEPTH - 2);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("m_vld",   32'(bus.bk_vld),   32'(exp_vld));
        chk("m_data",  bus.bk_data,       exp_data);
        chk("m_ocid",  32'(bus.bk_ocid),  32'(exp_ocid));
        chk("m_opsel", 32'(bus.bk_opsel), 32'(exp_opsel));
        chk("m_bz",    32'(bus.bk_bz),    32'(exp_bz));
        chk("m_ovf",   32'(bus.err_ovf),  32'(exp_ovf));
    endtask

    // Apply current inputs across one edge; outputs sampled 1 time unit later.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic drive(input logic a_en, input logic [2:0] ra, input logic [1:0] ba,
                         input logic b_en, input logic [2:0] rb, input logic [1:0] bb,
                         input logic [1:0] oc, input logic we, input logic [2:0] wrow,
                         input logic [31:0] wd);
        bus.req_a_en = a_en; bus.rowid_a = ra; bus.bankid_a = ba;
        bus.req_b_en = b_en; bus.rowid_b = rb; bus.bankid_b = bb;
        bus.req_ocid = oc;   bus.wr_en = we;   bus.wr_row = wrow; bus.wr_data = wd;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic a_en; logic [2:0] ra; logic [1:0] ba;
        logic b_en; logic [2:0] rb; logic [1:0] bb;
        logic [1:0] oc; logic we; logic [2:0] wrow; logic [31:0] wd;
        logic e_vld; logic [31:0] e_data; logic [1:0] e_ocid; logic e_opsel; logic e_bz;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int pulses;
        bit allow;

        tbl[0]  = '{0,0,0, 0,0,0, 0, 1,5,32'hDEADBEEF, 0,32'h0,        0,0,0};
        tbl[1]  = '{0,0,0, 0,0,0, 0, 1,1,32'h11111111, 0,32'h0,        0,0,0};
        tbl[2]  = '{0,0,0, 0,0,0, 0, 1,3,32'h33333333, 0,32'h0,        0,0,0};
        tbl[3]  = '{1,5,2, 0,0,0, 1, 0,0,32'h0,        0,32'h0,        0,0,0};
        tbl[4]  = '{0,0,0, 0,0,0, 0, 0,0,32'h0,        1,32'hDEADBEEF, 1,0,0};
        tbl[5]  = '{0,0,0, 0,0,0, 0, 0,0,32'h0,        0,32'hDEADBEEF, 1,0,0};
        tbl[6]  = '{1,1,2, 1,3,2, 3, 0,0,32'h0,        0,32'hDEADBEEF, 1,0,0};
        tbl[7]  = '{0,0,0, 0,0,0, 0, 0,0,32'h0,        1,32'h11111111, 3,0,0};
        tbl[8]  = '{0,0,0, 0,0,0, 0, 0,0,32'h0,        1,32'h33333333, 3,1,0};
        tbl[9]  = '{0,0,0, 0,0,0, 0, 0,0,32'h0,        0,32'h33333333, 3,1,0};
        tbl[10] = '{1,2,1, 1,6,0, 2, 0,0,32'h0,        0,32'h33333333, 3,1,0};
        tbl[11] = '{0,0,0, 0,0,0, 0, 0,0,32'h0,        0,32'h33333333, 3,1,0};

        // Reset
        idle();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_vld",  32'(bus.bk_vld),  0);
        chk("rst_data", bus.bk_data,      0);
        chk("rst_bz",   32'(bus.bk_bz),   0);
        chk("rst_ovf",  32'(bus.err_ovf), 0);
        rst = 1'b0;

        // Table: preload, single read latency, dual A/B hit, other-bank requests
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].a_en, tbl[i].ra, tbl[i].ba, tbl[i].b_en, tbl[i].rb, tbl[i].bb,
                  tbl[i].oc, tbl[i].we, tbl[i].wrow, tbl[i].wd);
            tick();
            chk($sformatf("tbl%0d_vld", i),   32'(bus.bk_vld),   32'(tbl[i].e_vld));
            chk($sformatf("tbl%0d_data", i),  bus.bk_data,       tbl[i].e_data);
            chk($sformatf("tbl%0d_ocid", i),  32'(bus.bk_ocid),  32'(tbl[i].e_ocid));
            chk($sformatf("tbl%0d_opsel", i), 32'(bus.bk_opsel), 32'(tbl[i].e_opsel));
            chk($sformatf("tbl%0d_bz", i),    32'(bus.bk_bz),    32'(tbl[i].e_bz));
        end

        // Write to the queued row on the would-be pop cycle
        drive(1, 4, 2, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h1234);
        tick();
        chk("t4_vld_wrcycle", 32'(bus.bk_vld), 32'(BYP));
        idle();
        tick();
        chk("t4_vld_after", 32'(bus.bk_vld), 32'(!BYP));
        chk("t4_data", bus.bk_data, 32'h1234);
        tick();

        // Fill with pops blocked by a held write, then overflow
        drive(1, 1, 2, 1, 3, 2, 0, 1, 7, 32'h77);
        tick();
        chk("t3_bz_cnt2", 32'(bus.bk_bz), 0);
        drive(1, 5, 2, 1, 4, 2, 1, 1, 7, 32'h77);
        tick();
        chk("t3_bz_full", 32'(bus.bk_bz), 1);
        chk("t3_ovf_pre", 32'(bus.err_ovf), 0);
        drive(1, 1, 2, 0, 0, 0, 2, 1, 7, 32'h77);
        tick();
        chk("t3_ovf", 32'(bus.err_ovf), 1);
        idle();
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (bus.bk_vld) pulses++;
        end
        chk("t3_drain_pulses", pulses, 4);
        chk("t3_ovf_sticky", 32'(bus.err_ovf), 1);

        // Reset with three entries queued
        drive(1, 2, 2, 1, 3, 2, 1, 1, 6, 32'h66);
        tick();
        drive(1, 5, 2, 0, 0, 0, 2, 1, 6, 32'h66);
        tick();
        chk("t6_bz_cnt3", 32'(bus.bk_bz), 1);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_vld", 32'(bus.bk_vld), 0);
        chk("t6_bz",  32'(bus.bk_bz),  0);
        chk("t6_ovf", 32'(bus.err_ovf), 0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.bk_vld) pulses++;
        end
        chk("t6_no_resp", pulses, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            rst   = ($urandom_range(0, 99) == 0);
            allow = !exp_bz || ($urandom_range(0, 19) == 0);
            bus.req_a_en = allow && ($urandom_range(0, 1) == 1);
            bus.req_b_en = allow && ($urandom_range(0, 2) == 0);
            bus.rowid_a  = 3'($urandom_range(0, 7));
            bus.rowid_b  = 3'($urandom_range(0, 7));
            bus.bankid_a = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'(BANKID);
            bus.bankid_b = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'(BANKID);
            bus.req_ocid = 2'($urandom_range(0, 3));
            bus.wr_en    = ($urandom_range(0, 9) < 3);
            bus.wr_row   = 3'($urandom_range(0, 7));
            bus.wr_data  = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
